// File: rtl/cluster_axi_route_ctrl_pkg.sv
// Shared types and cluster address-map constants for the cluster AXI route controller.
// rule_t matches the default parametrisation (PORT_W = 3, ADDR_WIDTH = 64).
package cluster_axi_route_ctrl_pkg;

    localparam int unsigned DFLT_NB_MST_PORTS = 4;
    localparam int unsigned DFLT_NB_RULES     = 4;
    localparam int unsigned DFLT_ADDR_WIDTH   = 64;
    localparam int unsigned DFLT_ID_WIDTH     = 4;
    localparam int unsigned DFLT_MAX_TXNS     = 8;
    localparam int unsigned DFLT_PORT_W       = $clog2(DFLT_NB_MST_PORTS + 1);

    localparam logic [31:0] CLUSTER_PERIPH_OFFS  = 32'h0020_0000;
    localparam logic [31:0] CLUSTER_TLB_CFG_OFFS = 32'h0040_0000;
    localparam logic [31:0] CLUSTER_EXT_OFFS     = 32'h0050_0000;
    localparam logic [31:0] CLUSTER_STRIDE       = 32'h0040_0000;

    typedef struct packed {
        logic [DFLT_PORT_W-1:0]     idx;
        logic [DFLT_ADDR_WIDTH-1:0] start_addr;
        logic [DFLT_ADDR_WIDTH-1:0] end_addr;
    } rule_t;

    typedef rule_t addr_map_rule_t;

endpackage

// File: rtl/cluster_axi_route_ctrl_addr_decode.sv
// Combinational rule-table decode, shared by the AW and AR route controllers.
// Optional macro CLUSTER_ROUTE_DEFAULT_PORT_EN adds a default port for unmatched addresses.
module cluster_axi_route_ctrl_addr_decode
    import cluster_axi_route_ctrl_pkg::*;
#(
    parameter int unsigned NB_MST_PORTS = DFLT_NB_MST_PORTS,
    parameter int unsigned NB_RULES     = DFLT_NB_RULES,
    parameter int unsigned ADDR_WIDTH   = DFLT_ADDR_WIDTH,
    localparam int unsigned PORT_W      = $clog2(NB_MST_PORTS + 1),
    localparam int unsigned RULE_W      = PORT_W + 2 * ADDR_WIDTH
) (
`ifdef CLUSTER_ROUTE_DEFAULT_PORT_EN
    input  logic                              en_default_i,
    input  logic [PORT_W-1:0]                 default_port_i,
`endif
    input  logic [NB_RULES-1:0][RULE_W-1:0]   addr_map_i,
    input  logic [ADDR_WIDTH-1:0]             addr_i,
    output logic [PORT_W-1:0]                 port_o,
    output logic                              decerr_o
);

    logic [PORT_W-1:0]     rule_idx   [NB_RULES];
    logic [ADDR_WIDTH-1:0] rule_start [NB_RULES];
    logic [ADDR_WIDTH-1:0] rule_end   [NB_RULES];
    logic [NB_RULES-1:0]   rule_hit;

    for (genvar r = 0; r < NB_RULES; r++) begin : g_rule
        assign rule_idx[r]   = addr_map_i[r][RULE_W-1 -: PORT_W];
        assign rule_start[r] = addr_map_i[r][2*ADDR_WIDTH-1 -: ADDR_WIDTH];
        assign rule_end[r]   = addr_map_i[r][ADDR_WIDTH-1:0];
        // An inverted or empty range can never satisfy both bounds.
        assign rule_hit[r]   = (addr_i >= rule_start[r]) && (addr_i < rule_end[r]);
    end

    always_comb begin
        port_o   = PORT_W'(NB_MST_PORTS);
        decerr_o = 1'b1;
        // Walk from the top so the lowest matching rule is the last writer.
        for (int r = NB_RULES - 1; r >= 0; r--) begin
            if (rule_hit[r]) begin
                port_o   = rule_idx[r];
                decerr_o = 1'b0;
            end
        end
`ifdef CLUSTER_ROUTE_DEFAULT_PORT_EN
        if (decerr_o && en_default_i) begin
            port_o   = default_port_i;
            decerr_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/cluster_axi_route_ctrl.sv
// Per-channel route/ordering controller: decodes the request port and stalls IDs that would change port while in flight.
// Optional macro CLUSTER_ROUTE_DEFAULT_PORT_EN adds en_default_i/default_port_i.
module cluster_axi_route_ctrl
    import cluster_axi_route_ctrl_pkg::*;
#(
    parameter int unsigned NB_MST_PORTS = DFLT_NB_MST_PORTS,
    parameter int unsigned NB_RULES     = DFLT_NB_RULES,
    parameter int unsigned ADDR_WIDTH   = DFLT_ADDR_WIDTH,
    parameter int unsigned ID_WIDTH     = DFLT_ID_WIDTH,
    parameter int unsigned MAX_TXNS     = DFLT_MAX_TXNS,
    localparam int unsigned PORT_W      = $clog2(NB_MST_PORTS + 1),
    localparam int unsigned CNT_W       = $clog2(MAX_TXNS + 1),
    localparam int unsigned RULE_W      = PORT_W + 2 * ADDR_WIDTH
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
`ifdef CLUSTER_ROUTE_DEFAULT_PORT_EN
    input  logic                              en_default_i,
    input  logic [PORT_W-1:0]                 default_port_i,
`endif
    input  logic [NB_RULES-1:0][RULE_W-1:0]   addr_map_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [ADDR_WIDTH-1:0]             req_addr_i,
    input  logic [ID_WIDTH-1:0]               req_id_i,
    output logic                              sel_valid_o,
    input  logic                              sel_ready_i,
    output logic [PORT_W-1:0]                 sel_port_o,
    output logic [ID_WIDTH-1:0]               sel_id_o,
    output logic                              sel_decerr_o,
    input  logic                              rsp_valid_i,
    input  logic [ID_WIDTH-1:0]               rsp_id_i,
    output logic                              busy_o,
    output logic                              underflow_o
);

    localparam int unsigned NUM_IDS = 2 ** ID_WIDTH;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TXNS);

    logic [PORT_W-1:0]   dec_port;
    logic                dec_decerr;

    logic                sel_valid_q, sel_valid_d;
    logic [PORT_W-1:0]   sel_port_q, sel_port_d;
    logic [ID_WIDTH-1:0] sel_id_q, sel_id_d;
    logic                sel_decerr_q, sel_decerr_d;
    logic                underflow_q, underflow_d;

    logic [CNT_W-1:0]    cnt_q  [NUM_IDS];
    logic [CNT_W-1:0]    cnt_d  [NUM_IDS];
    logic [PORT_W-1:0]   port_q [NUM_IDS];
    logic [PORT_W-1:0]   port_d [NUM_IDS];

    logic                slot_free;
    logic                id_block;
    logic                cnt_full;
    logic                accept;

    cluster_axi_route_ctrl_addr_decode #(
        .NB_MST_PORTS (NB_MST_PORTS),
        .NB_RULES     (NB_RULES),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) i_addr_decode (
`ifdef CLUSTER_ROUTE_DEFAULT_PORT_EN
        .en_default_i   (en_default_i),
        .default_port_i (default_port_i),
`endif
        .addr_map_i     (addr_map_i),
        .addr_i         (req_addr_i),
        .port_o         (dec_port),
        .decerr_o       (dec_decerr)
    );

    assign slot_free   = !sel_valid_q || sel_ready_i;
    assign id_block    = (cnt_q[req_id_i] != '0) && (port_q[req_id_i] != dec_port);
    assign cnt_full    = (cnt_q[req_id_i] == MAX_CNT);
    assign req_ready_o = slot_free && !id_block && !cnt_full;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        sel_valid_d  = sel_valid_q;
        sel_port_d   = sel_port_q;
        sel_id_d     = sel_id_q;
        sel_decerr_d = sel_decerr_q;
        if (accept) begin
            sel_valid_d  = 1'b1;
            sel_port_d   = dec_port;
            sel_id_d     = req_id_i;
            sel_decerr_d = dec_decerr;
        end else if (sel_ready_i) begin
            sel_valid_d  = 1'b0;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        port_d      = port_q;
        underflow_d = underflow_q;
        if (accept) begin
            cnt_d[req_id_i]  = cnt_q[req_id_i] + CNT_W'(1);
            port_d[req_id_i] = dec_port;
        end
        if (rsp_valid_i) begin
            if (cnt_q[rsp_id_i] == '0) begin
                underflow_d = 1'b1;
            end
            // A same-ID accept in this cycle cancels the retire.
            if (accept && (rsp_id_i == req_id_i)) begin
                cnt_d[rsp_id_i] = cnt_q[rsp_id_i];
            end else if (cnt_q[rsp_id_i] != '0) begin
                cnt_d[rsp_id_i] = cnt_q[rsp_id_i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_valid_q  <= 1'b0;
            sel_port_q   <= '0;
            sel_id_q     <= '0;
            sel_decerr_q <= 1'b0;
            underflow_q  <= 1'b0;
            for (int i = 0; i < NUM_IDS; i++) begin
                cnt_q[i]  <= '0;
                port_q[i] <= '0;
            end
        end else begin
            sel_valid_q  <= sel_valid_d;
            sel_port_q   <= sel_port_d;
            sel_id_q     <= sel_id_d;
            sel_decerr_q <= sel_decerr_d;
            underflow_q  <= underflow_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) begin
            busy_o = busy_o | (cnt_q[i] != '0);
        end
    end

    assign sel_valid_o  = sel_valid_q;
    assign sel_port_o   = sel_port_q;
    assign sel_id_o     = sel_id_q;
    assign sel_decerr_o = sel_decerr_q;
    assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_cluster_axi_route_ctrl.sv
// Directed scoreboard bench for cluster_axi_route_ctrl (default parameters).
module tb_cluster_axi_route_ctrl;
    import cluster_axi_route_ctrl_pkg::*;

    localparam logic [63:0] BASE   = 64'h1040_0000;
    localparam logic [63:0] TCDM   = BASE;
    localparam logic [63:0] PERIPH = BASE + 64'(CLUSTER_PERIPH_OFFS);

    logic        clk = 1'b0;
    logic        rst;
    rule_t [3:0] addr_map;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic [3:0]  req_id;
    logic        sel_valid, sel_ready;
    logic [2:0]  sel_port;
    logic [3:0]  sel_id;
    logic        sel_decerr;
    logic        rsp_valid;
    logic [3:0]  rsp_id;
    logic        busy, underflow;
`ifdef CLUSTER_ROUTE_DEFAULT_PORT_EN
    logic        en_default;
    logic [2:0]  default_port;
`endif

    typedef struct packed {
        logic [2:0] port;
        logic [3:0] id;
        logic       decerr;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cluster_axi_route_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
`ifdef CLUSTER_ROUTE_DEFAULT_PORT_EN
        .en_default_i   (en_default),
        .default_port_i (default_port),
`endif
        .addr_map_i     (addr_map),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_id_i       (req_id),
        .sel_valid_o    (sel_valid),
        .sel_ready_i    (sel_ready),
        .sel_port_o     (sel_port),
        .sel_id_o       (sel_id),
        .sel_decerr_o   (sel_decerr),
        .rsp_valid_i    (rsp_valid),
        .rsp_id_i       (rsp_id),
        .busy_o         (busy),
        .underflow_o    (underflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] port, input logic [3:0] id, input logic decerr);
        exp_t e;
        e.port   = port;
        e.id     = id;
        e.decerr = decerr;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_valid"}, sel_valid, 1);
        chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_port"}, sel_port, e.port);
            chk({tag, "_id"}, sel_id, e.id);
            chk({tag, "_decerr"}, sel_decerr, e.decerr);
        end
    endtask

    task automatic present(input logic [63:0] addr, input logic [3:0] id);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        req_id    = id;
        #1;
    endtask

    task automatic issue(input logic [63:0] addr, input logic [3:0] id,
                         input logic [2:0] port, input logic decerr, input string tag);
        present(addr, id);
        chk({tag, "_rdy"}, req_ready, 1);
        push_exp(port, id, decerr);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        pop_check(tag);
    endtask

    task automatic retire(input logic [3:0] id);
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_id    = id;
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
    endtask

    logic [63:0] map_addr [9];
    logic [2:0]  map_port [9];
    logic        map_err  [9];

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_id    = '0;
        sel_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_id    = '0;
`ifdef CLUSTER_ROUTE_DEFAULT_PORT_EN
        en_default   = 1'b0;
        default_port = 3'd3;
`endif
        addr_map[0] = '{idx: 3'd0, start_addr: TCDM, end_addr: TCDM + 64'h2_0000};
        addr_map[1] = '{idx: 3'd1, start_addr: PERIPH, end_addr: BASE + 64'(CLUSTER_TLB_CFG_OFFS)};
        addr_map[2] = '{idx: 3'd2, start_addr: 64'h1095_0000, end_addr: 64'h1090_0000};
        addr_map[3] = '{idx: 3'd3, start_addr: BASE, end_addr: 64'h10A0_0000};

        map_addr[0] = 64'h1041_FFFF;    map_port[0] = 3'd0; map_err[0] = 1'b0;
        map_addr[1] = 64'h1042_0000;    map_port[1] = 3'd3; map_err[1] = 1'b0;
        map_addr[2] = 64'h1060_0000;    map_port[2] = 3'd1; map_err[2] = 1'b0;
        map_addr[3] = 64'h107F_FFFF;    map_port[3] = 3'd1; map_err[3] = 1'b0;
        map_addr[4] = 64'h1080_0000;    map_port[4] = 3'd3; map_err[4] = 1'b0;
        map_addr[5] = 64'h1092_0000;    map_port[5] = 3'd3; map_err[5] = 1'b0;
        map_addr[6] = 64'h10A0_0000;    map_port[6] = 3'd4; map_err[6] = 1'b1;
        map_addr[7] = 64'h103F_FFFF;    map_port[7] = 3'd4; map_err[7] = 1'b1;
        map_addr[8] = 64'h1_1040_0010;  map_port[8] = 3'd4; map_err[8] = 1'b1;

        #12;
        chk("rst_sel_valid", sel_valid, 0);
        chk("rst_sel_port", sel_port, 0);
        chk("rst_sel_id", sel_id, 0);
        chk("rst_sel_decerr", sel_decerr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underflow", underflow, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic map hit, then retire.
        issue(TCDM + 64'h10, 4'd3, 3'd0, 1'b0, "map_tcdm");
        chk("map_busy", busy, 1);
        retire(4'd3);
        chk("map_busy_clear", busy, 0);
        chk("map_no_underflow", underflow, 0);

        // Boundaries, priority, inverted rule, high address bits.
        for (int i = 0; i < 9; i++) begin
            issue(map_addr[i], 4'(8 + i), map_port[i], map_err[i], $sformatf("map_tbl%0d", i));
        end
        for (int i = 0; i < 9; i++) begin
            retire(4'(8 + i));
        end
        chk("map_tbl_busy", busy, 0);

        issue(64'h100, 4'd4, 3'd4, 1'b1, "unmapped");
        retire(4'd4);
`ifdef CLUSTER_ROUTE_DEFAULT_PORT_EN
        en_default = 1'b1;
        issue(64'h100, 4'd4, 3'd3, 1'b0, "unmapped_default");
        retire(4'd4);
        en_default = 1'b0;
`endif

        // Ordering stall on ID 2.
        issue(TCDM, 4'd2, 3'd0, 1'b0, "ord_first");
        present(PERIPH, 4'd2);
        chk("ord_stall0", req_ready, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("ord_stall", req_ready, 0);
        end
        present(PERIPH + 64'h4, 4'd5);
        chk("ord_id5_rdy", req_ready, 1);
        push_exp(3'd1, 4'd5, 1'b0);
        @(posedge clk);
        #1;
        pop_check("ord_id5");
        present(PERIPH, 4'd2);
        chk("ord_stall_again", req_ready, 0);
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_id    = 4'd2;
        #1;
        chk("ord_retire_cycle", req_ready, 0);
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("ord_after_retire_rdy", req_ready, 1);
        push_exp(3'd1, 4'd2, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        pop_check("ord_id2_moved");
        retire(4'd2);
        retire(4'd5);
        chk("ord_busy", busy, 0);

        // Saturation at MAX_TXNS on ID 0.
        for (int i = 0; i < 8; i++) begin
            issue(TCDM + 64'h20, 4'd0, 3'd0, 1'b0, $sformatf("sat_fill%0d", i));
        end
        present(TCDM + 64'h20, 4'd0);
        chk("sat_stall", req_ready, 0);
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_id    = 4'd0;
        #1;
        chk("sat_stall_retire", req_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("sat_acc_ret_rdy", req_ready, 1);
        push_exp(3'd0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        pop_check("sat_acc_ret");
        @(negedge clk);
        #1;
        chk("sat_keep_rdy", req_ready, 1);
        push_exp(3'd0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        pop_check("sat_keep");
        @(negedge clk);
        #1;
        chk("sat_full_again", req_ready, 0);
        req_valid = 1'b0;
        repeat (8) retire(4'd0);
        chk("sat_busy", busy, 0);
        chk("sat_no_underflow", underflow, 0);

        // Backpressure.
        sel_ready = 1'b0;
        issue(PERIPH + 64'h4, 4'd6, 3'd1, 1'b0, "bp_load");
        present(TCDM, 4'd9);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("bp_rdy", req_ready, 0);
            chk("bp_valid", sel_valid, 1);
            chk("bp_port", sel_port, 1);
            chk("bp_id", sel_id, 6);
            chk("bp_decerr", sel_decerr, 0);
        end
        @(negedge clk);
        sel_ready = 1'b1;
        #1;
        chk("bp_release_rdy", req_ready, 1);
        push_exp(3'd0, 4'd9, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        pop_check("bp_next");
        retire(4'd6);
        retire(4'd9);
        chk("bp_busy", busy, 0);

        // Underflow, then asynchronous reset mid-burst.
        chk("uf_before", underflow, 0);
        retire(4'd7);
        chk("uf_set", underflow, 1);
        chk("uf_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("uf_sticky", underflow, 1);
        issue(TCDM, 4'd1, 3'd0, 1'b0, "rst_burst1");
        issue(PERIPH, 4'd2, 3'd1, 1'b0, "rst_burst2");
        sel_ready = 1'b0;
        present(TCDM + 64'h8, 4'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", sel_valid, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_underflow", underflow, 0);
        chk("rst_async_port", sel_port, 0);
        chk("rst_async_id", sel_id, 0);
        req_valid = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        sel_ready = 1'b1;
        issue(PERIPH, 4'd1, 3'd1, 1'b0, "rst_cleared_port");
        retire(4'd1);
        chk("end_busy", busy, 0);
        chk("end_underflow", underflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
